// File: rtl/instr_mem_responder_if.sv
// Bus between the fetch unit (initiator) and the instruction memory responder.
//   rw_mem     : 0 = initiator drives bus_in (address/data beat), 1 = initiator reads bus_out
//   wr_en      : sampled with the address beat, 1 = write transaction
//   bus_in     : address beat (low address bits) or write-data beat
//   bus_out    : registered read data from the responder
//   data_valid : bus_out holds the word for the current read transaction
interface instr_mem_responder_if #(
  parameter int DATA_W = 8
);
  logic              rw_mem;
  logic              wr_en;
  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              data_valid;

  modport master (
    output rw_mem, wr_en, bus_in,
    input  bus_out, data_valid
  );

  modport slave (
    input  rw_mem, wr_en, bus_in,
    output bus_out, data_valid
  );
endinterface

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the rw_mem bus used by the fetch unit.
// Holds 2**ADDR_W words of instruction/data storage, serves read and write
// transactions over the bus interface, and accepts side-band preload writes
// at any time (preload wins over a bus write, which then stalls).
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset (memory contents are kept)
//   bus        : slave side of instr_mem_responder_if
//   load_en    : preload write strobe
//   load_addr  : preload address
//   load_data  : preload data
module instr_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_mem_responder_if.slave  bus,
  input  logic                  load_en,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [DATA_W-1:0]     load_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WDATA
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              cap_addr;
  logic              bus_we;
  logic              rd_refresh;
  logic              dv_nxt;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READ: begin
        if (!bus.rw_mem) begin
          state_nxt = bus.wr_en ? WDATA : READ;
        end
      end
      WDATA: begin
        if (!bus.rw_mem && !load_en) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    cap_addr   = 1'b0;
    bus_we     = 1'b0;
    rd_refresh = 1'b0;
    dv_nxt     = 1'b0;
    case (state)
      IDLE: begin
        cap_addr = !bus.rw_mem;
      end
      READ: begin
        cap_addr   = !bus.rw_mem;
        rd_refresh = 1'b1;
        // Valid drops on the edge that starts the next transaction.
        dv_nxt     = bus.rw_mem;
      end
      WDATA: begin
        // Preload owns the write port this edge; the bus write retries next edge.
        bus_we = !bus.rw_mem && !load_en;
      end
      default: ;
    endcase
  end

  // Address and read-data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q         <= '0;
      bus.bus_out    <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      if (cap_addr) begin
        addr_q <= bus.bus_in[ADDR_W-1:0];
      end
      if (rd_refresh) begin
        bus.bus_out <= mem[addr_q];
      end
      bus.data_valid <= dv_nxt;
    end
  end

  // Storage: single write port shared by preload and bus, never reset
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end else if (bus_we) begin
      mem[addr_q] <= bus.bus_in;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

  logic       clk;
  logic       rst;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;

  int unsigned n_cmp;
  int unsigned n_bad;

  instr_mem_responder_if #(.DATA_W(8)) bus_if ();

  instr_mem_responder #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if.slave),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  // Address beat then one data edge; checks valid low on the address edge
  // and the expected word one edge later.
  task automatic read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus_if.rw_mem = 1'b0;
    bus_if.wr_en  = 1'b0;
    bus_if.bus_in = a;
    tick();
    check({tag, "_dv_addr_edge"}, {7'd0, bus_if.data_valid}, 8'h00);
    bus_if.rw_mem = 1'b1;
    tick();
    check({tag, "_data"}, bus_if.bus_out, exp);
    check({tag, "_dv"}, {7'd0, bus_if.data_valid}, 8'h01);
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    bus_if.rw_mem = 1'b0;
    bus_if.wr_en  = 1'b1;
    bus_if.bus_in = a;
    tick();
    bus_if.wr_en  = 1'b0;
    bus_if.bus_in = d;
    tick();
    bus_if.rw_mem = 1'b1;
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    rst           = 1'b1;
    load_en       = 1'b0;
    load_addr     = '0;
    load_data     = '0;
    bus_if.rw_mem = 1'b1;
    bus_if.wr_en  = 1'b0;
    bus_if.bus_in = '0;
    tick();
    tick();
    check("reset_bus_out", bus_if.bus_out, 8'h00);
    check("reset_dv", {7'd0, bus_if.data_valid}, 8'h00);
    rst = 1'b0;
    tick();
    check("idle_dv", {7'd0, bus_if.data_valid}, 8'h00);

    // 1: preload then read
    preload(8'h05, 8'hA7);
    read("t1", 8'h05, 8'hA7);

    // 2: bus write then read, then preload picked up by refresh
    write(8'h10, 8'h3C);
    tick();
    read("t2", 8'h10, 8'h3C);
    preload(8'h10, 8'hB5);
    check("t2_refresh_before", bus_if.bus_out, 8'h3C);
    tick();
    check("t2_refresh_after", bus_if.bus_out, 8'hB5);

    // 3: back-to-back reads
    preload(8'h00, 8'h11);
    preload(8'h01, 8'h22);
    preload(8'h02, 8'h33);
    read("t3_a0", 8'h00, 8'h11);
    read("t3_a1", 8'h01, 8'h22);
    read("t3_a2", 8'h02, 8'h33);

    // 4: preload collides with data beat
    preload(8'h20, 8'h00);
    preload(8'h21, 8'h00);
    bus_if.rw_mem = 1'b0;
    bus_if.wr_en  = 1'b1;
    bus_if.bus_in = 8'h20;
    tick();
    bus_if.wr_en  = 1'b0;
    bus_if.bus_in = 8'h55;
    load_en       = 1'b1;
    load_addr     = 8'h21;
    load_data     = 8'h66;
    tick();
    load_en = 1'b0;
    check("t4_dv_collision", {7'd0, bus_if.data_valid}, 8'h00);
    tick();
    bus_if.rw_mem = 1'b1;
    tick();
    read("t4_a21", 8'h21, 8'h66);
    read("t4_a20", 8'h20, 8'h55);

    // 5: async reset while waiting for the data beat
    preload(8'h30, 8'h4D);
    bus_if.rw_mem = 1'b0;
    bus_if.wr_en  = 1'b1;
    bus_if.bus_in = 8'h30;
    tick();
    bus_if.wr_en  = 1'b0;
    bus_if.bus_in = 8'hFF;
    check("t5_bus_out_pre", bus_if.bus_out, 8'h55);
    #2 rst = 1'b1;
    #1;
    check("t5_bus_out_rst", bus_if.bus_out, 8'h00);
    check("t5_dv_rst", {7'd0, bus_if.data_valid}, 8'h00);
    #1 rst = 1'b0;
    bus_if.rw_mem = 1'b1;
    tick();
    read("t5_a30", 8'h30, 8'h4D);

    // 6: initiator holds rw_mem=1 in WDATA, then data beat
    preload(8'h40, 8'h12);
    bus_if.rw_mem = 1'b0;
    bus_if.wr_en  = 1'b1;
    bus_if.bus_in = 8'h40;
    tick();
    bus_if.wr_en  = 1'b0;
    bus_if.rw_mem = 1'b1;
    bus_if.bus_in = 8'h77;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("t6_dv_wait", {7'd0, bus_if.data_valid}, 8'h00);
    end
    bus_if.rw_mem = 1'b0;
    bus_if.bus_in = 8'h9E;
    tick();
    bus_if.rw_mem = 1'b1;
    tick();
    read("t6_a40", 8'h40, 8'h9E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
